// File: rtl/misr_pkg.sv
// Shared types and constants for the MISR BIST sequencer and its compactor.
package misr_pkg;

  localparam int unsigned MISR_WIDTH = 32;
  localparam int unsigned MISR_CNT_W = 16;
  localparam logic [31:0] POLY_DEFAULT = 32'h0001_0811;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    RUN,
    CHECK,
    DONE
  } state_t;

  // {TM1,TM0} drive to the test-mode mux
  localparam logic [1:0] TM_IDLE  = 2'b00;
  localparam logic [1:0] TM_SEED  = 2'b01;
  localparam logic [1:0] TM_RUN   = 2'b10;
  localparam logic [1:0] TM_CHECK = 2'b11;

  function automatic logic [1:0] tm_of(input state_t s);
    logic [1:0] tm;
    case (s)
      SEED:    tm = TM_SEED;
      RUN:     tm = TM_RUN;
      CHECK:   tm = TM_CHECK;
      default: tm = TM_IDLE;
    endcase
    return tm;
  endfunction

endpackage

// File: rtl/misr_bist_ctrl_if.sv
// Session control / capture-side bus between the sequencer and its driver.
interface misr_bist_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) ();
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] n_patterns;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] golden;
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             pat_req;
  logic [1:0]       tm_sel;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] signature;

  modport master (
    output start, abort, n_patterns, seed, golden, data_in, data_valid,
    input  pat_req, tm_sel, busy, done, pass, signature
  );

  modport slave (
    input  start, abort, n_patterns, seed, golden, data_in, data_valid,
    output pat_req, tm_sel, busy, done, pass, signature
  );
endinterface

// File: rtl/crc_misr32.sv
// Signature register with one CRC/MISR compaction step per enabled cycle.
module crc_misr32 #(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY = 32'h0001_0811
) (
  input  logic             CK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_step;

  // Shift left, fold the outgoing MSB back through the tap mask, mix in the word.
  always_comb begin
    sig_step = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ data_in;
  end

  // Load has priority over compaction; otherwise the signature holds.
  always_ff @(posedge CK or negedge RESET) begin
    if (!RESET) begin
      sig <= '0;
    end else if (load) begin
      sig <= load_val;
    end else if (en) begin
      sig <= sig_step;
    end
  end

endmodule

// File: rtl/misr_bist_ctrl.sv
// Session sequencer: seeds the compactor, requests N words, compares to golden.
//
//  state | meaning
//  IDLE  | waiting for start
//  SEED  | load seed into compactor, load pattern counter
//  RUN   | pat_req high, compact each valid word until counter reaches 0
//  CHECK | compare signature with latched golden
//  DONE  | one-cycle done pulse, back to IDLE
module misr_bist_ctrl
  import misr_pkg::*;
#(
  parameter int unsigned WIDTH = MISR_WIDTH,
  parameter logic [WIDTH-1:0] POLY = POLY_DEFAULT,
  parameter int unsigned CNT_W = MISR_CNT_W
) (
  input  logic             CK,
  input  logic             RESET,
  misr_bist_ctrl_if.slave  bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_q;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] golden_q;
  logic             done_q;
  logic             pass_q;
  logic             sig_load;
  logic             sig_en;
  logic [WIDTH-1:0] sig;

  // Abort suppresses both loading and compaction so the signature is retained.
  always_comb begin
    sig_load = (state == SEED) && !bus.abort;
    sig_en   = (state == RUN) && bus.data_valid && (cnt != '0) && !bus.abort;
  end

  crc_misr32 #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .CK       (CK),
    .RESET    (RESET),
    .load     (sig_load),
    .load_val (seed_q),
    .en       (sig_en),
    .data_in  (bus.data_in),
    .sig      (sig)
  );

  // Sequencer FSM with registered done/pass; abort overrides every state.
  always_ff @(posedge CK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      n_q      <= '0;
      seed_q   <= '0;
      golden_q <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state  <= IDLE;
        pass_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              n_q      <= bus.n_patterns;
              seed_q   <= bus.seed;
              golden_q <= bus.golden;
              pass_q   <= 1'b0;
              state    <= SEED;
            end
          end
          SEED: begin
            cnt   <= n_q;
            state <= (n_q != '0) ? RUN : CHECK;
          end
          RUN: begin
            if (bus.data_valid && (cnt != '0)) begin
              cnt <= cnt - 1'b1;
              if (cnt == CNT_W'(1)) begin
                state <= CHECK;
              end
            end
          end
          CHECK: begin
            pass_q <= (sig == golden_q);
            done_q <= 1'b1;
            state  <= DONE;
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Status decoded from state only.
  always_comb begin
    bus.pat_req = (state == RUN);
    bus.busy    = (state == SEED) || (state == RUN) || (state == CHECK);
    bus.tm_sel  = tm_of(state);
  end

  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = sig;

endmodule
